// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux4_stream
//  Description : 1-to-4 valid/ready stream demultiplexer with one-entry output
//                registers per lane. The lane comes from {s1,s0} or from an
//                internal round-robin counter (TDM de-interleave).
//  Revision    : 1.0 - initial release
// ============================================================================
module demux4_stream #(
  parameter int WIDTH    = 8,
  parameter bit AUTO_SEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             s1,
  input  logic             s0,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready,
  output logic [1:0]       lane
);

  localparam int c_LANES = 4;

  logic [WIDTH-1:0] r_y [c_LANES];
  logic [3:0]       r_valid;
  logic [1:0]       r_rr;
  logic [1:0]       w_k;
  logic [3:0]       w_free;
  logic             w_xfer;

  // The counter exists in both modes; it simply goes unobserved when the
  // lane comes from the select pins.
  assign w_k     = AUTO_SEL ? r_rr : {s1, s0};
  assign w_free  = ~r_valid | y_ready;
  assign d_ready = !rst && w_free[w_k];
  assign w_xfer  = d_valid && d_ready;
  assign lane    = w_k;

  // frame_sync outranks the increment; a concurrent transfer already used
  // the old count through w_k.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= 2'd0;
    end else if (frame_sync) begin
      r_rr <= 2'd0;
    end else if (w_xfer) begin
      r_rr <= r_rr + 2'd1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < c_LANES; k++) begin : g_lane
      // A write wins over a drain, so a lane that drains and refills in the
      // same cycle keeps valid high with no bubble.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_y[k]     <= '0;
          r_valid[k] <= 1'b0;
        end else if (w_xfer && (w_k == 2'(k))) begin
          r_y[k]     <= d;
          r_valid[k] <= 1'b1;
        end else if (r_valid[k] && y_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  endgenerate

  assign y0      = r_y[0];
  assign y1      = r_y[1];
  assign y2      = r_y[2];
  assign y3      = r_y[3];
  assign y_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux4_stream
//  Description : Drives a select-pin instance and a round-robin instance with
//                identical stimulus and compares both against lane models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       d_valid;
  logic       s1, s0;
  logic       frame_sync;
  logic [3:0] y_ready;

  logic       m_d_ready, a_d_ready;
  logic [7:0] m_y0, m_y1, m_y2, m_y3, a_y0, a_y1, a_y2, a_y3;
  logic [3:0] m_y_valid, a_y_valid;
  logic [1:0] m_lane, a_lane;
  logic [7:0] m_y [4];
  logic [7:0] a_y [4];

  int total = 0;
  int bad   = 0;

  // Reference state: what each lane register holds, and the TDM slot number.
  logic [7:0] my_m [4];
  logic [7:0] my_a [4];
  bit         mv_m [4];
  bit         mv_a [4];
  int         slot;

  always #5 clk = ~clk;

  demux4_stream #(.WIDTH(8), .AUTO_SEL(1'b0)) u_man (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(m_d_ready),
    .s1(s1), .s0(s0), .frame_sync(frame_sync),
    .y0(m_y0), .y1(m_y1), .y2(m_y2), .y3(m_y3),
    .y_valid(m_y_valid), .y_ready(y_ready), .lane(m_lane)
  );

  demux4_stream #(.WIDTH(8), .AUTO_SEL(1'b1)) u_auto (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(a_d_ready),
    .s1(s1), .s0(s0), .frame_sync(frame_sync),
    .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3),
    .y_valid(a_y_valid), .y_ready(y_ready), .lane(a_lane)
  );

  always_comb begin
    m_y[0] = m_y0; m_y[1] = m_y1; m_y[2] = m_y2; m_y[3] = m_y3;
    a_y[0] = a_y0; a_y[1] = a_y1; a_y[2] = a_y2; a_y[3] = a_y3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check handshake/lane before the edge, advance the
  // models on the edge, then check every lane register of both instances.
  task automatic step(input bit r, input logic [7:0] dd, input bit dv,
                      input int sel, input logic [3:0] yr, input bit fs);
    bit rdy_m, rdy_a, take_m, take_a;
    int ka;
    rst = r; d = dd; d_valid = dv; {s1, s0} = 2'(sel); y_ready = yr; frame_sync = fs;
    #1;
    ka    = slot;
    rdy_m = !r && (!mv_m[sel] || yr[sel]);
    rdy_a = !r && (!mv_a[ka] || yr[ka]);
    chk("m_d_ready", 32'(m_d_ready), 32'(rdy_m));
    chk("a_d_ready", 32'(a_d_ready), 32'(rdy_a));
    if (!r) begin
      chk("m_lane", 32'(m_lane), 32'(sel));
      chk("a_lane", 32'(a_lane), 32'(ka));
    end
    @(posedge clk);
    take_m = dv && rdy_m;
    take_a = dv && rdy_a;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        my_m[i] = 8'h00; mv_m[i] = 1'b0;
        my_a[i] = 8'h00; mv_a[i] = 1'b0;
      end else begin
        if (take_m && i == sel) begin my_m[i] = dd; mv_m[i] = 1'b1; end
        else if (yr[i]) mv_m[i] = 1'b0;
        if (take_a && i == ka) begin my_a[i] = dd; mv_a[i] = 1'b1; end
        else if (yr[i]) mv_a[i] = 1'b0;
      end
    end
    if (r || fs) slot = 0;
    else if (take_a) slot = (slot + 1) % 4;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("m_y%0d", i), 32'(m_y[i]), 32'(my_m[i]));
      chk($sformatf("m_valid%0d", i), 32'(m_y_valid[i]), 32'(mv_m[i]));
      chk($sformatf("a_y%0d", i), 32'(a_y[i]), 32'(my_a[i]));
      chk($sformatf("a_valid%0d", i), 32'(a_y_valid[i]), 32'(mv_a[i]));
    end
  endtask

  initial begin
    slot = 0;
    for (int i = 0; i < 4; i++) begin
      my_m[i] = 8'h00; mv_m[i] = 1'b0; my_a[i] = 8'h00; mv_a[i] = 1'b0;
    end

    // Reset state
    step(1, 8'h00, 0, 0, 4'hF, 0);
    step(1, 8'h00, 0, 0, 4'hF, 0);
    chk("rst_valid", 32'(m_y_valid), 32'h0);

    // Back-to-back to all four lanes by select
    for (int i = 0; i < 4; i++) begin
      step(0, 8'hA0 + 8'(i), 1, i, 4'hF, 0);
      chk("t1_ready_held", 32'(m_d_ready), 32'h1);
    end
    chk("t1_y0", 32'(m_y0), 32'hA0);
    chk("t1_y3", 32'(m_y3), 32'hA3);

    // Head-of-line stall on lane 2, then divert to lane 1
    step(0, 8'h55, 1, 2, 4'hF, 0);
    step(0, 8'h66, 1, 2, 4'b1011, 0);
    chk("t2_stalled_y2", 32'(m_y2), 32'h55);
    step(0, 8'h66, 1, 1, 4'b1011, 0);
    chk("t2_y1", 32'(m_y1), 32'h66);
    chk("t2_hold_v2", 32'(m_y_valid[2]), 32'h1);
    step(0, 8'h00, 0, 0, 4'hF, 0);
    chk("t2_drain_v2", 32'(m_y_valid[2]), 32'h0);

    // Same-cycle drain and refill on lane 0
    step(0, 8'h22, 1, 0, 4'hF, 0);
    step(0, 8'h11, 1, 0, 4'hF, 0);
    chk("t3_y0", 32'(m_y0), 32'h11);
    chk("t3_v0", 32'(m_y_valid[0]), 32'h1);

    // Round-robin: eight words wrap twice through the lanes
    step(1, 8'h00, 0, 0, 4'hF, 0);
    for (int i = 1; i <= 8; i++) step(0, 8'(i), 1, 0, 4'hF, 0);
    chk("t4_a_y0", 32'(a_y0), 32'h05);
    chk("t4_a_y3", 32'(a_y3), 32'h08);
    chk("t4_slot0", 32'(a_lane), 32'h0);

    // frame_sync with a concurrent transfer
    step(0, 8'hC1, 1, 0, 4'hF, 0);
    step(0, 8'hC2, 1, 0, 4'hF, 0);
    step(0, 8'hCC, 1, 0, 4'hF, 1);
    chk("t5_a_y2", 32'(a_y2), 32'hCC);
    step(0, 8'hDD, 1, 0, 4'hF, 0);
    chk("t5_a_y0", 32'(a_y0), 32'hDD);

    // Mid-stream reset with every lane full
    for (int i = 0; i < 4; i++) step(0, 8'hE0 + 8'(i), 1, i, 4'h0, 0);
    chk("t6_full", 32'(m_y_valid), 32'hF);
    step(1, 8'h00, 0, 0, 4'h0, 0);
    chk("t6_valid", 32'(m_y_valid), 32'h0);
    chk("t6_a_y1", 32'(a_y1), 32'h00);
    step(0, 8'h77, 1, 3, 4'hF, 0);
    chk("t6_resume", 32'(m_y3), 32'h77);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 8'($urandom), bit'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
